// File: rtl/resize_expand.sv
// Re-expands packed narrow fixed-point lanes to a wide format with saturation, and
// recovers frame alignment from sync_in_i (word indexing, sync regeneration, sat stats).
module resize_expand #(
    parameter int    DIN_WIDTH  = 9,
    parameter int    DIN_POINT  = 8,
    parameter string DATA_TYPE  = "signed",
    parameter int    PARALLEL   = 4,
    parameter int    SHIFT      = -6,
    parameter int    DOUT_WIDTH = 18,
    parameter int    DOUT_POINT = 16,
    parameter int    FRAME_LEN  = 1024,
    parameter int    DELAY      = 0
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [DIN_WIDTH*PARALLEL-1:0]  din_i,
    input  logic                           din_valid_i,
    input  logic                           sync_in_i,
    output logic [DOUT_WIDTH*PARALLEL-1:0] dout_o,
    output logic                           dout_valid_o,
    output logic                           sync_out_o,
    output logic                           warning_o,
    output logic                           sync_err_o,
    output logic [15:0]                    frame_sat_o
);

    localparam bit IsSigned = (DATA_TYPE == "signed");
    localparam int S        = (DOUT_POINT - DIN_POINT) + SHIFT;
    localparam int SL       = (S > 0) ? S : 0;
    localparam int SR       = (S < 0) ? -S : 0;
    // Wide enough to hold any shifted input plus both saturation bounds as signed values.
    localparam int XW       = ((DIN_WIDTH + SL > DOUT_WIDTH) ? DIN_WIDTH + SL : DOUT_WIDTH) + 2;
    localparam int CW       = $clog2(FRAME_LEN);
    localparam int IW       = DIN_WIDTH * PARALLEL;
    localparam int OW       = DOUT_WIDTH * PARALLEL;

    localparam logic signed [XW-1:0] MaxV = IsSigned ?
        $signed({{(XW-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}}) :
        $signed({{(XW-DOUT_WIDTH){1'b0}}, {DOUT_WIDTH{1'b1}}});
    localparam logic signed [XW-1:0] MinV = IsSigned ?
        $signed({{(XW-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}}) :
        $signed({XW{1'b0}});

    localparam logic [0:0] StWaitSync = 1'b0;
    localparam logic [0:0] StRun      = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept, first;
    logic          sync_err_q, sync_err_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        first      = 1'b0;
        sync_err_d = 1'b0;
        if (sync_in_i) begin
            sync_err_d = (state_q == StRun) && (cnt_q != '0);
            state_d    = StRun;
            cnt_d      = '0;
        end
        // A sync in the same cycle makes this word index 0 of the new frame.
        if (din_valid_i && ((state_q == StRun) || sync_in_i)) begin
            accept = 1'b1;
            first  = (cnt_d == '0);
            cnt_d  = cnt_d + CW'(1);
        end
    end

    logic [IW-1:0] s1_data_q;
    logic          s1_valid_q, s1_first_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StWaitSync;
            cnt_q      <= '0;
            sync_err_q <= 1'b0;
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sync_err_q <= sync_err_d;
            s1_valid_q <= accept;
            s1_first_q <= first;
            if (accept) begin
                s1_data_q <= din_i;
            end
        end
    end

    logic [OW-1:0]       exp_data;
    logic [PARALLEL-1:0] lane_sat;

    for (genvar l = 0; l < PARALLEL; l++) begin : g_lane
        logic [DIN_WIDTH-1:0]  lane_in;
        logic signed [XW-1:0]  ext, shf;
        logic [DOUT_WIDTH-1:0] res;
        logic                  sat;

        assign lane_in = s1_data_q[l*DIN_WIDTH +: DIN_WIDTH];
        assign ext     = $signed({{(XW-DIN_WIDTH){IsSigned & lane_in[DIN_WIDTH-1]}}, lane_in});
        assign shf     = (S >= 0) ? (ext <<< SL) : (ext >>> SR);

        always_comb begin
            sat = 1'b0;
            res = shf[DOUT_WIDTH-1:0];
            if (shf > MaxV) begin
                sat = 1'b1;
                res = MaxV[DOUT_WIDTH-1:0];
            end else if (shf < MinV) begin
                sat = 1'b1;
                res = MinV[DOUT_WIDTH-1:0];
            end
        end

        assign exp_data[l*DOUT_WIDTH +: DOUT_WIDTH] = res;
        assign lane_sat[l]                          = sat;
    end

    logic [OW-1:0] st2_data;
    logic          st2_valid, st2_sync, st2_warn;

    assign st2_valid = s1_valid_q;
    assign st2_sync  = s1_valid_q & s1_first_q;
    assign st2_warn  = s1_valid_q & (|lane_sat);
    assign st2_data  = s1_valid_q ? exp_data : '0;

    // Entry 0 is the shift/saturate register; entries 1..DELAY are the extra stages.
    logic [OW-1:0] pipe_data_q [DELAY+1];
    logic [DELAY:0] pipe_valid_q, pipe_sync_q, pipe_warn_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i <= DELAY; i++) begin
                pipe_data_q[i] <= '0;
            end
            pipe_valid_q <= '0;
            pipe_sync_q  <= '0;
            pipe_warn_q  <= '0;
        end else begin
            pipe_data_q[0]  <= st2_data;
            pipe_valid_q[0] <= st2_valid;
            pipe_sync_q[0]  <= st2_sync;
            pipe_warn_q[0]  <= st2_warn;
            for (int i = 1; i <= DELAY; i++) begin
                pipe_data_q[i]  <= pipe_data_q[i-1];
                pipe_valid_q[i] <= pipe_valid_q[i-1];
                pipe_sync_q[i]  <= pipe_sync_q[i-1];
                pipe_warn_q[i]  <= pipe_warn_q[i-1];
            end
        end
    end

    // Frame statistics track the word entering the output register so they move with sync_out.
    logic lst_valid, lst_sync, lst_warn;

    if (DELAY == 0) begin : g_lst_direct
        assign lst_valid = st2_valid;
        assign lst_sync  = st2_sync;
        assign lst_warn  = st2_warn;
    end else begin : g_lst_piped
        assign lst_valid = pipe_valid_q[DELAY-1];
        assign lst_sync  = pipe_sync_q[DELAY-1];
        assign lst_warn  = pipe_warn_q[DELAY-1];
    end

    logic [15:0] sat_run_q, sat_run_d;
    logic [15:0] frame_sat_q, frame_sat_d;

    always_comb begin
        sat_run_d   = sat_run_q;
        frame_sat_d = frame_sat_q;
        if (lst_valid) begin
            if (lst_sync) begin
                frame_sat_d = sat_run_q;
                sat_run_d   = {15'b0, lst_warn};
            end else if (lst_warn && (sat_run_q != 16'hFFFF)) begin
                sat_run_d = sat_run_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sat_run_q   <= '0;
            frame_sat_q <= '0;
        end else begin
            sat_run_q   <= sat_run_d;
            frame_sat_q <= frame_sat_d;
        end
    end

    assign dout_o       = pipe_data_q[DELAY];
    assign dout_valid_o = pipe_valid_q[DELAY];
    assign sync_out_o   = pipe_sync_q[DELAY];
    assign warning_o    = pipe_warn_q[DELAY];
    assign sync_err_o   = sync_err_q;
    assign frame_sat_o  = frame_sat_q;

endmodule

// File: tb/tb_resize_expand.sv
// Randomized bench for resize_expand: three builds (S=2 signed, S=20 signed with DELAY=1,
// S=20 unsigned) share one stimulus stream and are compared against a frame/arithmetic model.
module tb_resize_expand;

    localparam int FL = 8;
    localparam int HN = 4096;

    logic        clk = 1'b0;
    logic        rst, din_valid, sync_in;
    logic [35:0] din;

    logic [71:0] dout_a, dout_b, dout_c;
    logic        dv_a, dv_b, dv_c, so_a, so_b, so_c, wa_a, wa_b, wa_c, se_a, se_b, se_c;
    logic [15:0] fs_a, fs_b, fs_c;

    always #5 clk = ~clk;

    resize_expand #(.FRAME_LEN(FL)) u_a (
        .clk_i(clk), .rst_i(rst), .din_i(din), .din_valid_i(din_valid), .sync_in_i(sync_in),
        .dout_o(dout_a), .dout_valid_o(dv_a), .sync_out_o(so_a), .warning_o(wa_a),
        .sync_err_o(se_a), .frame_sat_o(fs_a)
    );

    resize_expand #(.SHIFT(12), .FRAME_LEN(FL), .DELAY(1)) u_b (
        .clk_i(clk), .rst_i(rst), .din_i(din), .din_valid_i(din_valid), .sync_in_i(sync_in),
        .dout_o(dout_b), .dout_valid_o(dv_b), .sync_out_o(so_b), .warning_o(wa_b),
        .sync_err_o(se_b), .frame_sat_o(fs_b)
    );

    resize_expand #(.DATA_TYPE("unsigned"), .SHIFT(12), .FRAME_LEN(FL)) u_c (
        .clk_i(clk), .rst_i(rst), .din_i(din), .din_valid_i(din_valid), .sync_in_i(sync_in),
        .dout_o(dout_c), .dout_valid_o(dv_c), .sync_out_o(so_c), .warning_o(wa_c),
        .sync_err_o(se_c), .frame_sat_o(fs_c)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state: input-side frame tracking plus per-edge history.
    int          cyc      = 0;
    bit          running  = 1'b0;
    int          cnt      = 0;
    int          last_rst = -1;
    logic [35:0] din_h   [HN];
    bit          acc_h   [HN];
    bit          first_h [HN];
    bit          err_h   [HN];
    int          sat_run [3];
    int          fs_exp  [3];

    task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Plain arithmetic: scale by 2^s with floor on right shifts, then clamp to the 18-bit range.
    task automatic expand(input logic [35:0] d, input int s, input bit sgn,
                          output logic [71:0] o, output bit sat);
        longint v, lo, hi;
        o   = '0;
        sat = 1'b0;
        lo  = sgn ? -131072 : 0;
        hi  = sgn ? 131071 : 262143;
        for (int l = 0; l < 4; l++) begin
            v = longint'(d[9*l +: 9]);
            if (sgn && v >= 256) v = v - 512;
            if (s >= 0) v = v * (longint'(1) << s);
            else        v = v >>> (-s);
            if (v > hi) begin
                v   = hi;
                sat = 1'b1;
            end else if (v < lo) begin
                v   = lo;
                sat = 1'b1;
            end
            o[18*l +: 18] = v[17:0];
        end
    endtask

    task automatic model_edge(input bit v, input bit s, input bit r, input logic [35:0] d);
        din_h[cyc]   = d;
        acc_h[cyc]   = 1'b0;
        first_h[cyc] = 1'b0;
        err_h[cyc]   = 1'b0;
        if (r) begin
            running  = 1'b0;
            cnt      = 0;
            last_rst = cyc;
        end else begin
            err_h[cyc] = s && running && (cnt != 0);
            if (s) begin
                running = 1'b1;
                cnt     = 0;
            end
            if (v && running) begin
                acc_h[cyc]   = 1'b1;
                first_h[cyc] = (cnt == 0);
                cnt          = (cnt + 1) % FL;
            end
        end
    endtask

    task automatic check_inst(input int id, input int lat, input int s, input bit sgn,
                              input logic [71:0] d, input logic v, input logic so,
                              input logic w, input logic se, input logic [15:0] fs);
        int          m;
        bit          vld, sat, fst;
        logic [71:0] ed;
        string       nm;
        m   = cyc - (lat - 1);
        vld = 1'b0;
        fst = 1'b0;
        sat = 1'b0;
        ed  = '0;
        if (m >= 0) begin
            if (last_rst <= m && acc_h[m]) begin
                vld = 1'b1;
                fst = first_h[m];
                expand(din_h[m], s, sgn, ed, sat);
            end
        end
        if (last_rst == cyc) begin
            sat_run[id] = 0;
            fs_exp[id]  = 0;
        end else if (vld) begin
            if (fst) begin
                fs_exp[id]  = sat_run[id];
                sat_run[id] = sat ? 1 : 0;
            end else if (sat && sat_run[id] < 65535) begin
                sat_run[id]++;
            end
        end
        nm = $sformatf("%s@%0d", (id == 0) ? "a" : ((id == 1) ? "b" : "c"), cyc);
        check_eq({nm, " dout_valid"}, 72'(v), 72'(vld));
        check_eq({nm, " sync_out"}, 72'(so), 72'(fst));
        check_eq({nm, " warning"}, 72'(w), 72'(sat));
        check_eq({nm, " dout"}, d, ed);
        check_eq({nm, " sync_err"}, 72'(se), 72'(err_h[cyc]));
        check_eq({nm, " frame_sat"}, 72'(fs), 72'(fs_exp[id]));
    endtask

    task automatic step(input bit v, input bit s, input bit r, input logic [35:0] d);
        din       = d;
        din_valid = v;
        sync_in   = s;
        rst       = r;
        @(posedge clk);
        model_edge(v, s, r, d);
        #1;
        check_inst(0, 2, 2, 1'b1, dout_a, dv_a, so_a, wa_a, se_a, fs_a);
        check_inst(1, 3, 20, 1'b1, dout_b, dv_b, so_b, wa_b, se_b, fs_b);
        check_inst(2, 2, 20, 1'b0, dout_c, dv_c, so_c, wa_c, se_c, fs_c);
        cyc++;
    endtask

    // Random word with roughly half the lanes zeroed so the wide-shift builds do not always saturate.
    function automatic logic [35:0] rnd_word();
        logic [63:0] t;
        logic [35:0] w;
        t = {$urandom(), $urandom()};
        w = t[35:0];
        for (int l = 0; l < 4; l++) begin
            if ($urandom_range(1) == 0) w[9*l +: 9] = '0;
        end
        return w;
    endfunction

    localparam logic [35:0] DWord = {9'h000, 9'h001, 9'h100, 9'h0FF};
    localparam logic [71:0] ExpA  = {18'h00000, 18'h00004, 18'h3FC00, 18'h003FC};
    localparam logic [71:0] ExpB  = {18'h00000, 18'h1FFFF, 18'h20000, 18'h1FFFF};
    localparam logic [71:0] ExpC  = {18'h00000, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF};

    initial begin
        for (int i = 0; i < 3; i++) begin
            sat_run[i] = 0;
            fs_exp[i]  = 0;
        end
        din = '0; din_valid = 1'b0; sync_in = 1'b0; rst = 1'b1;

        repeat (3) step(1'b1, 1'b1, 1'b1, rnd_word());
        repeat (5) step(1'b1, 1'b0, 1'b0, rnd_word());

        // Known-answer word as frame word 0.
        step(1'b1, 1'b1, 1'b0, DWord);
        step(1'b0, 1'b0, 1'b0, '0);
        check_eq("known a dout", dout_a, ExpA);
        check_eq("known a sync_out", 72'(so_a), 72'd1);
        check_eq("known a warning", 72'(wa_a), 72'd0);
        check_eq("known c dout", dout_c, ExpC);
        step(1'b0, 1'b0, 1'b0, '0);
        check_eq("known b dout", dout_b, ExpB);
        check_eq("known b warning", 72'(wa_b), 72'd1);

        // Continuous words across frame boundaries.
        repeat (23) step(1'b1, 1'b0, 1'b0, rnd_word());

        // Resync at frame index 5.
        repeat (5) step(1'b1, 1'b0, 1'b0, rnd_word());
        step(1'b1, 1'b1, 1'b0, rnd_word());
        check_eq("resync sync_err", 72'(se_a), 72'd1);
        repeat (10) step(1'b1, 1'b0, 1'b0, rnd_word());

        // Frame with three saturating words (for the wide-shift builds) and gapped valid.
        step(1'b1, 1'b1, 1'b0, '0);
        for (int i = 1; i < FL; i++) begin
            if (i % 2 == 0) step(1'b0, 1'b0, 1'b0, rnd_word());
            step(1'b1, 1'b0, 1'b0, (i == 1 || i == 3 || i == 6) ? 36'h1 : 36'h0);
        end
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);
        check_eq("sat frame b frame_sat", 72'(fs_b), 72'd3);
        check_eq("sat frame a frame_sat", 72'(fs_a), 72'd0);

        // Reset mid-frame, then words without a sync.
        repeat (3) step(1'b1, 1'b0, 1'b0, rnd_word());
        repeat (2) step(1'b1, 1'b0, 1'b1, rnd_word());
        repeat (5) step(1'b1, 1'b0, 1'b0, rnd_word());
        check_eq("post-reset dout_valid", 72'(dv_a), 72'd0);
        step(1'b0, 1'b1, 1'b0, '0);
        repeat (12) step(1'b1, 1'b0, 1'b0, rnd_word());

        // Random traffic: gaps, occasional syncs and resets.
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(3) != 0, $urandom_range(15) == 0,
                 $urandom_range(79) == 0, rnd_word());
        end
        repeat (4) step(1'b0, 1'b0, 1'b0, '0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
